pipeline_stall_ctrl: RTL and testbench

PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

---
 rtl/pipeline_stall_ctrl_pkg.sv | 18 +
 rtl/pipeline_stall_ctrl_if.sv | 28 ++
 rtl/pipeline_stall_ctrl_sat_counter.sv | 30 +++
 rtl/pipeline_stall_ctrl.sv | 105 ++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_stall_ctrl_pkg.sv
// rtl/pipeline_stall_ctrl_pkg.sv - shared types and constants for the stall controller
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    IMEM_WAIT  = 2'd2
  } stall_state_e;

  localparam logic [4:0]  REG_ZERO  = 5'd0;
  localparam logic [31:0] NOP_INSTR = 32'h0;

  // Word the IF/ID register captures for a given flush decision.
  function automatic logic [31:0] if_id_word(input logic flush, input logic [31:0] fetched);
    return flush ? NOP_INSTR : fetched;
  endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// rtl/pipeline_stall_ctrl_if.sv - hazard inputs and pipeline control outputs of the stall controller
interface pipeline_stall_ctrl_if;
  logic        MemRead_EX;
  logic [4:0]  rt_EX;
  logic [4:0]  rs_ID;
  logic [4:0]  rt_ID;
  logic        branch_taken;
  logic        imem_ready;
  logic        PC_write;
  logic        IF_ID_write;
  logic        IF_ID_flush;
  logic        ID_EX_bubble;
  logic        imem_timeout;
  logic [15:0] stall_cycles;
  logic [15:0] flush_count;

  modport master (
    output MemRead_EX, rt_EX, rs_ID, rt_ID, branch_taken, imem_ready,
    input  PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, imem_timeout,
    input  stall_cycles, flush_count
  );

  modport slave (
    input  MemRead_EX, rt_EX, rs_ID, rt_ID, branch_taken, imem_ready,
    output PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, imem_timeout,
    output stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// rtl/pipeline_stall_ctrl_sat_counter.sv - 16-bit saturating event counter, async active-low clear
// Only built with PIPELINE_STALL_CTRL_PERF_EN, the sole configuration that instantiates it.
`ifdef PIPELINE_STALL_CTRL_PERF_EN
module sat_counter (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        en,
  output logic [15:0] count
);
  logic [15:0] count_q;
  logic [15:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
endmodule
`endif

// File: rtl/pipeline_stall_ctrl.sv
// rtl/pipeline_stall_ctrl.sv - load-use / branch / imem-wait stall controller with Mealy outputs
// Perf counters are built only with PIPELINE_STALL_CTRL_PERF_EN defined.
module pipeline_stall_ctrl
  import pipeline_pkg::*;
#(
  parameter int LOAD_LAT     = 1,
  parameter int IMEM_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipeline_stall_ctrl_if.slave bus
);
  localparam logic [1:0]  LOAD_INIT     = 2'(LOAD_LAT - 1);
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(IMEM_TIMEOUT);

  stall_state_e state_q, state_d;
  logic [1:0]   load_cnt_q, load_cnt_d;
  logic [15:0]  wait_cnt_q, wait_cnt_d;
  logic         timeout_q, timeout_d;
  logic         hazard;
  logic         pc_write, if_id_write, if_id_flush, id_ex_bubble;

  assign hazard = bus.MemRead_EX && (bus.rt_EX != REG_ZERO) &&
                  ((bus.rt_EX == bus.rs_ID) || (bus.rt_EX == bus.rt_ID));

  // Every branch falls back to RUN with cleared counters unless it says otherwise.
  always_comb begin
    state_d      = RUN;
    load_cnt_d   = '0;
    wait_cnt_d   = '0;
    timeout_d    = timeout_q;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    if (bus.branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (!bus.imem_ready) begin
      pc_write    = 1'b0;
      if_id_flush = 1'b1;
      state_d     = IMEM_WAIT;
      wait_cnt_d  = (wait_cnt_q == 16'hFFFF) ? wait_cnt_q : wait_cnt_q + 16'd1;
      if (wait_cnt_d >= TIMEOUT_LIMIT) begin
        timeout_d = 1'b1;
      end
    end else if (state_q == LOAD_STALL) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      if (load_cnt_q != 2'd1) begin
        state_d    = LOAD_STALL;
        load_cnt_d = load_cnt_q - 2'd1;
      end
    end else if (hazard) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      if (LOAD_LAT > 1) begin
        state_d    = LOAD_STALL;
        load_cnt_d = LOAD_INIT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      load_cnt_q <= '0;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // Reset forces every control output low, overriding the RUN defaults.
  assign bus.PC_write     = rst_n & pc_write;
  assign bus.IF_ID_write  = rst_n & if_id_write;
  assign bus.IF_ID_flush  = rst_n & if_id_flush;
  assign bus.ID_EX_bubble = rst_n & id_ex_bubble;
  assign bus.imem_timeout = timeout_q;

`ifdef PIPELINE_STALL_CTRL_PERF_EN
  sat_counter u_stall_cnt (
    .clk   (clk),
    .clr_n (rst_n),
    .en    (rst_n & ~pc_write),
    .count (bus.stall_cycles)
  );

  sat_counter u_flush_cnt (
    .clk   (clk),
    .clr_n (rst_n),
    .en    (rst_n & if_id_flush),
    .count (bus.flush_count)
  );
`else
  assign bus.stall_cycles = 16'd0;
  assign bus.flush_count  = 16'd0;
`endif
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb/tb_pipeline_stall_ctrl.sv - directed scoreboard bench for LOAD_LAT=1 and LOAD_LAT=3 controllers
module tb_pipeline_stall_ctrl;

  typedef struct packed {
    logic [3:0]  ctl;
    logic        tmo;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  // ctl = {PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble}
  localparam logic [3:0] RN = 4'b1100;
  localparam logic [3:0] ST = 4'b0001;
  localparam logic [3:0] BR = 4'b1111;
  localparam logic [3:0] WT = 4'b0110;
  localparam logic [3:0] RS = 4'b0000;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   sc1 = 0, fc1 = 0, sc3 = 0, fc3 = 0;
  exp_t q1[$];
  exp_t q3[$];

  pipeline_stall_ctrl_if if1 ();
  pipeline_stall_ctrl_if if3 ();

  pipeline_stall_ctrl #(.LOAD_LAT(1), .IMEM_TIMEOUT(4)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  pipeline_stall_ctrl #(.LOAD_LAT(3), .IMEM_TIMEOUT(4)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model(input logic [3:0] c, input logic t, input logic rstn,
                       inout int sc, inout int fc, output exp_t e);
    e.ctl = c;
    e.tmo = t;
`ifdef PIPELINE_STALL_CTRL_PERF_EN
    e.sc = rstn ? 16'(sc) : 16'd0;
    e.fc = rstn ? 16'(fc) : 16'd0;
`else
    e.sc = 16'd0;
    e.fc = 16'd0;
`endif
    if (!rstn) begin
      sc = 0;
      fc = 0;
    end else begin
      sc = sc + (c[3] ? 0 : 1);
      fc = fc + (c[1] ? 1 : 0);
    end
  endtask

  task automatic check(input string tag, input logic [3:0] ctl, input logic tmo,
                       input logic [15:0] sc, input logic [15:0] fc, input exp_t e);
    checks++;
    assert (ctl === e.ctl) else begin
      errors++;
      $error("FAIL %s ctl got %b want %b at %0t", tag, ctl, e.ctl, $time);
    end
    checks++;
    assert (tmo === e.tmo) else begin
      errors++;
      $error("FAIL %s imem_timeout got %b want %b at %0t", tag, tmo, e.tmo, $time);
    end
    checks++;
    assert (sc === e.sc) else begin
      errors++;
      $error("FAIL %s stall_cycles got %0d want %0d at %0t", tag, sc, e.sc, $time);
    end
    checks++;
    assert (fc === e.fc) else begin
      errors++;
      $error("FAIL %s flush_count got %0d want %0d at %0t", tag, fc, e.fc, $time);
    end
  endtask

  task automatic drive(input logic mr, input logic [4:0] rte, input logic [4:0] rsi,
                       input logic [4:0] rti, input logic br, input logic rdy);
    if1.MemRead_EX = mr;  if3.MemRead_EX = mr;
    if1.rt_EX = rte;      if3.rt_EX = rte;
    if1.rs_ID = rsi;      if3.rs_ID = rsi;
    if1.rt_ID = rti;      if3.rt_ID = rti;
    if1.branch_taken = br; if3.branch_taken = br;
    if1.imem_ready = rdy; if3.imem_ready = rdy;
  endtask

  task automatic step(input logic mr, input logic [4:0] rte, input logic [4:0] rsi,
                      input logic [4:0] rti, input logic br, input logic rdy, input logic rstn,
                      input logic [3:0] c1, input logic [3:0] c3, input logic t);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rstn;
    drive(mr, rte, rsi, rti, br, rdy);
    model(c1, t, rstn, sc1, fc1, e);
    q1.push_back(e);
    model(c3, t, rstn, sc3, fc3, e);
    q3.push_back(e);
    @(negedge clk);
    checks++;
    assert (q1.size() == 1 && q3.size() == 1) else begin
      errors++;
      $error("FAIL scoreboard depth got %0d/%0d want 1/1", q1.size(), q3.size());
    end
    if (q1.size() > 0)
      check("lat1", {if1.PC_write, if1.IF_ID_write, if1.IF_ID_flush, if1.ID_EX_bubble},
            if1.imem_timeout, if1.stall_cycles, if1.flush_count, q1.pop_front());
    if (q3.size() > 0)
      check("lat3", {if3.PC_write, if3.IF_ID_write, if3.IF_ID_flush, if3.ID_EX_bubble},
            if3.imem_timeout, if3.stall_cycles, if3.flush_count, q3.pop_front());
  endtask

  task automatic idle(input logic [3:0] c1, input logic [3:0] c3, input logic t);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, c1, c3, t);
  endtask

  task automatic low(input logic [3:0] c1, input logic [3:0] c3, input logic t);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, c1, c3, t);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);

    // reset state, then release into RUN
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, RS, RS, 1'b0);
    idle(RN, RN, 1'b0);

    // load-use via rs_ID: 1 stall vs 3 stalls
    step(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, ST, ST, 1'b0);
    idle(RN, ST, 1'b0);
    idle(RN, ST, 1'b0);
    idle(RN, RN, 1'b0);

    // load-use via rt_ID
    step(1'b1, 5'd8, 5'd0, 5'd8, 1'b0, 1'b1, 1'b1, ST, ST, 1'b0);
    idle(RN, ST, 1'b0);
    idle(RN, ST, 1'b0);
    idle(RN, RN, 1'b0);

    // no hazard: rt_EX==0, no register match, not a load
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, RN, RN, 1'b0);
    step(1'b1, 5'd7, 5'd5, 5'd6, 1'b0, 1'b1, 1'b1, RN, RN, 1'b0);
    step(1'b0, 5'd5, 5'd5, 5'd5, 1'b0, 1'b1, 1'b1, RN, RN, 1'b0);

    // branch on the 2nd stall cycle ends the stall
    step(1'b1, 5'd8, 5'd0, 5'd8, 1'b0, 1'b1, 1'b1, ST, ST, 1'b0);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, BR, BR, 1'b0);
    idle(RN, RN, 1'b0);
    idle(RN, RN, 1'b0);

    // hazard with imem not ready: wait wins, hazard re-evaluated afterwards
    step(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, WT, WT, 1'b0);
    step(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, ST, ST, 1'b0);
    idle(RN, ST, 1'b0);
    idle(RN, ST, 1'b0);
    idle(RN, RN, 1'b0);

    // stall abandoned by an imem wait does not resume
    step(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, ST, ST, 1'b0);
    low(WT, WT, 1'b0);
    idle(RN, RN, 1'b0);

    // 3-cycle imem wait stays below timeout
    low(WT, WT, 1'b0);
    low(WT, WT, 1'b0);
    low(WT, WT, 1'b0);
    idle(RN, RN, 1'b0);

    // branch beats imem not ready
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, BR, BR, 1'b0);
    idle(RN, RN, 1'b0);

    // 6-cycle wait: flag visible from the 5th low cycle and sticky
    for (int k = 1; k <= 6; k++) begin
      low(WT, WT, (k >= 5));
    end
    idle(RN, RN, 1'b1);
    idle(RN, RN, 1'b1);

    // branch inside IMEM_WAIT
    low(WT, WT, 1'b1);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, BR, BR, 1'b1);
    idle(RN, RN, 1'b1);

    // reset pulse inside IMEM_WAIT clears everything
    low(WT, WT, 1'b1);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, RS, RS, 1'b0);
    idle(RN, RN, 1'b0);

    // perf scenario: two stalls and one flush on the LOAD_LAT=1 unit
    step(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, ST, ST, 1'b0);
    idle(RN, ST, 1'b0);
    step(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, ST, ST, 1'b0);
    idle(RN, RN, 1'b0);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, BR, BR, 1'b0);
    idle(RN, RN, 1'b0);
    idle(RN, RN, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
